// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the block-fill memory responder.
// Requester ids, FSM state encoding and default geometry live here.
package mem_fill_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;
  localparam int BLOCK_WORDS_DEF = 8;
  localparam int LATENCY_DEF     = 4;
  localparam int MEM_WORDS_DEF   = 1 << (ADDR_W_DEF - 1);
  localparam int WORD_IDX_W      = $clog2(BLOCK_WORDS_DEF);

  // Wide enough for a write countdown of up to 8 cycles.
  localparam int LAT_CNT_W = 4;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_fill_responder_if.sv
// Cache-miss bus between the two caches (master) and the memory responder (slave).
interface mem_fill_responder_if
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = WORD_IDX_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_grant;
  logic              d_grant;
  logic              rvalid;
  logic [IDX_W-1:0]  rword;
  logic [DATA_W-1:0] rdata;
  logic              i_done;
  logic              d_done;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    output i_grant, d_grant, rvalid, rword, rdata, i_done, d_done, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    input  i_grant, d_grant, rvalid, rword, rdata, i_done, d_done, busy
  );

endinterface

// File: rtl/mem_delay_pipe.sv
// Fixed-latency shift register carrying beat tags alongside the array read data.
// Tag stage 0 lines up with the array read register; only valids are reset.
module mem_delay_pipe #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              id_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              valid_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              id_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o
);

  logic [LATENCY-1:0] vld_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];
  logic [LATENCY-1:0] id_q;
  logic [LATENCY-1:0] last_q;
  logic [DATA_W-1:0]  dat_s;

  // Valid bits: the only state that reset must clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {LATENCY{1'b0}};
    end else begin
      vld_q[0] <= push_i;
      for (int s = 1; s < LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  // Tag payload travels with its valid bit.
  always_ff @(posedge clk) begin
    idx_q[0]  <= idx_i;
    id_q[0]   <= id_i;
    last_q[0] <= last_i;
    for (int s = 1; s < LATENCY; s++) begin
      idx_q[s]  <= idx_q[s-1];
      id_q[s]   <= id_q[s-1];
      last_q[s] <= last_q[s-1];
    end
  end

  generate
    if (LATENCY > 1) begin : g_dat
      logic [DATA_W-1:0] dat_q [LATENCY-1];

      // Read data enters one stage late, so it needs LATENCY-1 more stages.
      always_ff @(posedge clk) begin
        dat_q[0] <= rd_data_i;
        for (int s = 1; s < LATENCY - 1; s++) begin
          dat_q[s] <= dat_q[s-1];
        end
      end

      assign dat_s = dat_q[LATENCY-2];
    end else begin : g_nodat
      assign dat_s = rd_data_i;
    end
  endgenerate

  assign valid_o = vld_q[LATENCY-1];
  assign idx_o   = idx_q[LATENCY-1];
  assign id_o    = id_q[LATENCY-1];
  assign last_o  = last_q[LATENCY-1];
  assign data_o  = vld_q[LATENCY-1] ? dat_s : {DATA_W{1'b0}};
  assign empty_o = (vld_q == {LATENCY{1'b0}});

endmodule

// File: rtl/mem_fill_responder.sv
// Main-memory responder: arbitrates icache/dcache misses, streams block fills
// through a fixed-latency pipe and performs single-word write-through stores.
module mem_fill_responder
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF,
  parameter int MEM_WORDS   = MEM_WORDS_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_fill_responder_if.slave bus
);

  localparam int                   IDX_W    = $clog2(BLOCK_WORDS);
  localparam int                   WADDR_W  = ADDR_W - 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [LAT_CNT_W-1:0] WR_LAST  = LAT_CNT_W'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [WADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LAT_CNT_W-1:0] wcnt_q, wcnt_d;

  logic                 push_s;
  logic                 we_s;
  logic                 fill_done_s;
  logic [WADDR_W-1:0]   rd_word_s;
  logic                 addr_lsb_unused_s;

  logic [DATA_W-1:0]    mem_q [MEM_WORDS];
  logic [DATA_W-1:0]    rd_q;

  logic                 pv_s;
  logic [IDX_W-1:0]     pidx_s;
  logic                 pid_s;
  logic                 plast_s;
  logic [DATA_W-1:0]    pdata_s;
  logic                 pempty_s;

  assign addr_lsb_unused_s = bus.i_addr[0] ^ bus.d_addr[0];

  // Blocks are aligned, so the word counter simply replaces the low index bits.
  assign rd_word_s   = {waddr_q[WADDR_W-1:IDX_W], idx_q};
  assign fill_done_s = pv_s && plast_s;

  // Transaction state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= {WADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      owner_q <= REQ_I;
      last_q  <= REQ_I;
      idx_q   <= {IDX_W{1'b0}};
      wcnt_q  <= {LAT_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Arbitration, issue sequencing and write timing.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    push_s  = 1'b0;
    we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d  = {IDX_W{1'b0}};
        wcnt_d = {LAT_CNT_W{1'b0}};
        // dcache wins unless it had the previous turn and icache is waiting.
        if (bus.d_req && !((last_q == REQ_D) && bus.i_req)) begin
          owner_d = REQ_D;
          last_d  = REQ_D;
          waddr_d = bus.d_addr[ADDR_W-1:1];
          wdata_d = bus.d_wdata;
          state_d = bus.d_wr ? WRITE : ISSUE;
        end else if (bus.i_req) begin
          owner_d = REQ_I;
          last_d  = REQ_I;
          waddr_d = bus.i_addr[ADDR_W-1:1];
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        push_s = 1'b1;
        idx_d  = idx_q + IDX_W'(1'b1);
        if (idx_q == IDX_LAST) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (fill_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      WRITE: begin
        we_s   = (wcnt_q == {LAT_CNT_W{1'b0}});
        wcnt_d = wcnt_q + LAT_CNT_W'(1'b1);
        if (wcnt_q == WR_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Backing store: not reset; the read register is the first latency stage.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_q] <= wdata_q;
    end
    rd_q <= mem_q[rd_word_s];
  end

  mem_delay_pipe #(
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_s),
    .idx_i     (idx_q),
    .id_i      (owner_q),
    .last_i    (idx_q == IDX_LAST),
    .rd_data_i (rd_q),
    .valid_o   (pv_s),
    .idx_o     (pidx_s),
    .id_o      (pid_s),
    .last_o    (plast_s),
    .data_o    (pdata_s),
    .empty_o   (pempty_s)
  );

  assign bus.i_grant = (state_q != IDLE) && (owner_q == REQ_I);
  assign bus.d_grant = (state_q != IDLE) && (owner_q == REQ_D);
  assign bus.rvalid  = pv_s;
  assign bus.rword   = pidx_s;
  assign bus.rdata   = pdata_s;
  assign bus.i_done  = fill_done_s && (pid_s == REQ_I);
  assign bus.d_done  = (fill_done_s && (pid_s == REQ_D)) ||
                       ((state_q == WRITE) && (wcnt_q == WR_LAST));
  assign bus.busy    = (state_q != IDLE) || !pempty_s;

endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Main-memory responder on the far side of the cache miss interface.
- Serves block-fill requests from the instruction cache and the data cache, plus single-word write-through stores from the data cache.
- Arbitrates between the two caches and returns fill data as a pipelined beat stream with fixed access latency.
- Its busy/done timing is what drives the cache busy signals that stall the CPU pipeline.

Parameters:
- ADDR_W, 16, byte-address width; bit 0 ignored (word aligned).
- DATA_W, 16, word width.
- BLOCK_WORDS, 8, words per cache block; power of two.
- LATENCY, 4, cycles from read issue to data beat; range 1..8.
- MEM_WORDS, 32768, backing-store depth = 2^(ADDR_W-1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  icache fill request; level, held until i_done.
- i_addr  in  ADDR_W  icache miss address (any word in block).
- d_req  in  1  dcache request; level, held until d_done.
- d_wr  in  1  1 = single-word write, 0 = block fill.
- d_addr  in  ADDR_W  dcache address.
- d_wdata  in  DATA_W  dcache write data.
- i_grant  out  1  icache owns current transaction.
- d_grant  out  1  dcache owns current transaction.
- rvalid  out  1  fill data beat valid.
- rword  out  log2(BLOCK_WORDS)  word index of beat within block.
- rdata  out  DATA_W  fill data; 0 when rvalid=0.
- i_done  out  1  one-cycle pulse on last icache beat.
- d_done  out  1  one-cycle pulse on last dcache beat or write completion.
- busy  out  1  FSM not IDLE or delay pipe non-empty.

Behaviour:
- Reset:
  - All outputs 0; FSM to IDLE; delay pipe valid bits cleared.
  - Backing-store array is not reset.
  - Reset mid-transaction aborts it immediately; no beats or done are emitted after release.
- FSM states: IDLE, ISSUE, DRAIN, WRITE.
- IDLE:
  - Samples requests each cycle.
  - Winner's address and direction are registered at the edge. Later changes to addr or req are ignored until done.
  - Dropping req mid-transaction does not cancel it.
- Arbitration:
  - dcache has priority, except when the last grant went to dcache and i_req is high; then icache wins.
  - Only one grant is high at a time. It is held from the first cycle after acceptance through the done cycle.
- Fill timing (cycle 0 = accept cycle in IDLE):
  - Block base = addr & ~(2*BLOCK_WORDS-1).
  - ISSUE lasts BLOCK_WORDS cycles (1..BLOCK_WORDS). In cycle k+1 it reads word k at base+2k and pushes it into the delay pipe.
  - Beat k appears in cycle 1+k+LATENCY with rvalid=1, rword=k. Beats are back-to-back, in order, no gaps.
  - After the last issue, FSM goes to DRAIN until the pipe is empty.
  - Requester's done pulses in the same cycle as beat BLOCK_WORDS-1.
  - Grant drops and FSM is IDLE the cycle after done; a new request can be accepted in that cycle.
  - Defaults (LATENCY=4, 8 words): grant cycles 1..12, beats cycles 5..12, done cycle 12, next grant cycle 14.
- Write (dcache, d_wr=1):
  - WRITE lasts LATENCY cycles (1..LATENCY).
  - Array updated at word addr[ADDR_W-1:1] at the end of cycle 1.
  - d_done pulses in cycle LATENCY.
  - No rvalid.
- Read-after-write: a fill accepted after a write's done returns the written data.
- Address boundary: blocks are aligned, so there is no wrap. Block 0xFFF0 returns words 0xFFF0..0xFFFE.
- Word index counter is exactly log2(BLOCK_WORDS) bits; the ISSUE→DRAIN transition uses the terminal count, not overflow.
- The array uses a synchronous read with a registered address. That read register counts as stage 1 of LATENCY.

Decomposition:
- Shared package mem_fill_pkg holds:
  - State enum {IDLE, ISSUE, DRAIN, WRITE}.
  - Requester id constants REQ_I/REQ_D.
  - Helper constant WORD_IDX_W = log2(BLOCK_WORDS).
- Sub-module mem_delay_pipe: LATENCY-stage shift register carrying {valid, word index, requester id, last flag}.
  - Data is aligned to the array read output.
  - Exposes an empty flag.
  - Reset clears valids only.

Test Plan:
- Preload mem[word n]=3n; i_req with i_addr=0x0012 → i_grant cycles 1..12; rvalid cycles 5..12; rword 0..7; rdata 0x18,0x1B,...,0x2D; i_done cycle 12 only.
- i_req and d_req (fill) both rise in cycle 0 after reset → d_grant first (cycles 1..12); i_grant cycles 14..25; i_done cycle 25.
- d_wr=1, d_addr=0x0024, d_wdata=0xBEEF → d_done cycle 4, no rvalid; then fill at 0x0020 → beat rword=2 carries 0xBEEF.
- d_req and i_req held high continuously → grants alternate d, i, d, i; each done pulse is one cycle; grants are never high together.
- rst_n low in cycle 7 of a fill → rvalid, grants, done, busy all 0 asynchronously; nothing emitted after release; a fresh fill then completes with correct timing.
- Fill at 0xFFFE → base 0xFFF0; beats return words 0xFFF0..0xFFFE in order; no access at 0x0000.
